// File: rtl/fpu_sub_pkg.sv
// rtl/fpu_sub_pkg.sv - shared width and bias helpers for the effective-subtraction pipe
package fpu_sub_pkg;

  function automatic int fpu_dw(input int man_w, input int grd_w);
    return 1 + man_w + grd_w;
  endfunction

  function automatic int fpu_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Bits needed to hold a shift/count in 0..dw inclusive.
  function automatic int fpu_shw(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/fpu_sub_if.sv
// rtl/fpu_sub_if.sv - operand/result handshake bundle for fpu_sub_pipe
interface fpu_sub_if #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52,
  parameter int GRD_W = 2
);
  import fpu_sub_pkg::*;

  localparam int OPW = 1 + EXP_W + MAN_W;
  localparam int DW  = fpu_dw(MAN_W, GRD_W);

  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   opa;
  logic [OPW-1:0]   opb;
  logic             op_sub;
  logic             i2f;
  logic             out_valid;
  logic             out_ready;
  logic             sign_o;
  logic [EXP_W-1:0] exp_o;
  logic [DW-1:0]    man_o;
  logic             sticky_o;
  logic             zero_o;

  modport master (
    output in_valid, opa, opb, op_sub, i2f, out_ready,
    input  in_ready, out_valid, sign_o, exp_o, man_o, sticky_o, zero_o
  );

  modport slave (
    input  in_valid, opa, opb, op_sub, i2f, out_ready,
    output in_ready, out_valid, sign_o, exp_o, man_o, sticky_o, zero_o
  );

endinterface

// File: rtl/fpu_lzc.sv
// rtl/fpu_lzc.sv - combinational leading-zero counter, returns WIDTH for an all-zero input
module fpu_lzc #(
  parameter  int WIDTH = 55,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CW-1:0]    count_o
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) count_o = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_sub_pipe.sv
// rtl/fpu_sub_pipe.sv - four-stage |large|-|small| datapath: swap, align, subtract, normalise
module fpu_sub_pipe
  import fpu_sub_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52,
  parameter int GRD_W = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  fpu_sub_if.slave bus
);

  localparam int DW  = fpu_dw(MAN_W, GRD_W);
  localparam int SW  = fpu_shw(DW);
  localparam int EW1 = EXP_W + 1;
  localparam logic [EW1-1:0] I2F_BASE = EW1'(fpu_bias(EXP_W) + MAN_W);

  typedef struct packed {
    logic             sign;
    logic             zsign;
    logic             i2f;
    logic [EXP_W-1:0] el;
    logic [MAN_W-1:0] ml;
    logic [EXP_W-1:0] es;
    logic [MAN_W-1:0] ms;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic             zsign;
    logic             i2f;
    logic [EXP_W-1:0] el;
    logic [DW-1:0]    big;
    logic [DW-1:0]    shifted;
    logic             sticky;
  } s2_t;

  typedef struct packed {
    logic             sign;
    logic             zsign;
    logic             i2f;
    logic [EXP_W-1:0] el;
    logic [DW-1:0]    diff;
    logic [SW-1:0]    lz;
    logic             sticky;
  } s3_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [DW-1:0]    man;
    logic             sticky;
    logic             zero;
  } s4_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  s4_t s4_d, s4_q;

  logic v1_q, v2_q, v3_q, v4_q;
  logic ld1, ld2, ld3, ld4;

  assign ld4          = !v4_q | bus.out_ready;
  assign ld3          = !v3_q | ld4;
  assign ld2          = !v2_q | ld3;
  assign ld1          = !v1_q | ld2;
  assign bus.in_ready = ld1 & !flush;

  // Stage 1: order operands by magnitude. In i2f mode the integer sits in opa's
  // mantissa with no hidden bit, and opb is +0.
  logic             sa, sb, sb_eff, a_ge_b;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;

  always_comb begin
    {sa, ea, ma} = bus.opa;
    {sb, eb, mb} = bus.opb;
    if (bus.i2f) begin
      ea = '0;
      sb = 1'b0;
      eb = '0;
      mb = '0;
    end
    sb_eff     = sb ^ bus.op_sub;
    a_ge_b     = (ea > eb) | ((ea == eb) & (ma >= mb));
    s1_d       = '0;
    s1_d.sign  = a_ge_b ? sa : sb_eff;
    s1_d.zsign = sa & sb_eff;
    s1_d.i2f   = bus.i2f;
    s1_d.el    = a_ge_b ? ea : eb;
    s1_d.ml    = a_ge_b ? ma : mb;
    s1_d.es    = a_ge_b ? eb : ea;
    s1_d.ms    = a_ge_b ? mb : ma;
  end

  // Stage 2: denormals sit at exponent 1, hence the correction term on ed.
  logic [EW1-1:0]  ed;
  logic [SW-1:0]   sh_amt;
  logic [DW-1:0]   sub_full;
  logic [2*DW-1:0] sh_wide;

  always_comb begin
    ed       = {1'b0, s1_q.el} - {1'b0, s1_q.es}
             - EW1'((s1_q.el != '0) && (s1_q.es == '0));
    sh_amt   = (ed >= EW1'(DW)) ? SW'(DW) : ed[SW-1:0];
    sub_full = {s1_q.es != '0, s1_q.ms, {GRD_W{1'b0}}};
    sh_wide  = {sub_full, {DW{1'b0}}} >> sh_amt;
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.zsign   = s1_q.zsign;
    s2_d.i2f     = s1_q.i2f;
    s2_d.el      = s1_q.el;
    s2_d.big     = {s1_q.el != '0, s1_q.ml, {GRD_W{1'b0}}};
    s2_d.shifted = sh_wide[2*DW-1:DW];
    s2_d.sticky  = |sh_wide[DW-1:0];
  end

  // Stage 3: subtracting sticky makes the truncated difference exact-floor.
  logic [DW-1:0] diff;
  logic [SW-1:0] lz;

  assign diff = s2_q.big - s2_q.shifted - DW'(s2_q.sticky);

  fpu_lzc #(.WIDTH(DW)) u_lzc (
    .data_i  (diff),
    .count_o (lz)
  );

  always_comb begin
    s3_d        = '0;
    s3_d.sign   = s2_q.sign;
    s3_d.zsign  = s2_q.zsign;
    s3_d.i2f    = s2_q.i2f;
    s3_d.el     = s2_q.el;
    s3_d.diff   = diff;
    s3_d.lz     = lz;
    s3_d.sticky = s2_q.sticky;
  end

  // Stage 4: normalise, clamping to a denormal when the shift would underflow.
  logic [EW1-1:0] eff, base, lz_w;

  always_comb begin
    eff         = (s3_q.el == '0) ? EW1'(1) : {1'b0, s3_q.el};
    base        = s3_q.i2f ? I2F_BASE : {1'b0, s3_q.el};
    lz_w        = EW1'(s3_q.lz);
    s4_d        = '0;
    s4_d.sign   = s3_q.sign;
    s4_d.sticky = s3_q.sticky;
    if (s3_q.diff == '0) begin
      s4_d.zero = 1'b1;
      s4_d.sign = s3_q.zsign;
    end else if (s3_q.i2f || (lz_w < eff)) begin
      s4_d.man = s3_q.diff << s3_q.lz;
      s4_d.exp = EXP_W'(base - lz_w);
    end else begin
      s4_d.man = s3_q.diff << (eff - EW1'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      s1_q <= '0;
    end else if (flush) begin
      v1_q <= 1'b0;
    end else if (ld1) begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) s1_q <= s1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0;
      s2_q <= '0;
    end else if (flush) begin
      v2_q <= 1'b0;
    end else if (ld2) begin
      v2_q <= v1_q;
      if (v1_q) s2_q <= s2_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q <= 1'b0;
      s3_q <= '0;
    end else if (flush) begin
      v3_q <= 1'b0;
    end else if (ld3) begin
      v3_q <= v2_q;
      if (v2_q) s3_q <= s3_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v4_q <= 1'b0;
      s4_q <= '0;
    end else if (flush) begin
      v4_q <= 1'b0;
    end else if (ld4) begin
      v4_q <= v3_q;
      if (v3_q) s4_q <= s4_d;
    end
  end

  assign bus.out_valid = v4_q;
  assign bus.sign_o    = s4_q.sign;
  assign bus.exp_o     = s4_q.exp;
  assign bus.man_o     = s4_q.man;
  assign bus.sticky_o  = s4_q.sticky;
  assign bus.zero_o    = s4_q.zero;

endmodule

// File: tb/tb_fpu_sub_pipe.sv
// tb/tb_fpu_sub_pipe.sv - randomized scoreboard bench for fpu_sub_pipe with directed corner cases
module tb_fpu_sub_pipe;

  localparam int EXP_W = 11;
  localparam int MAN_W = 52;
  localparam int GRD_W = 2;
  localparam int DW    = 1 + MAN_W + GRD_W;
  localparam int RW    = 1 + EXP_W + DW + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  fpu_sub_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .GRD_W(GRD_W)) bus ();

  fpu_sub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .GRD_W(GRD_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc      = 0;
  int            n_pop    = 0;
  int            last_lat = 0;
  logic          last_acc = 1'b0;
  logic [RW-1:0] last_res = '0;
  logic [RW-1:0] exp_q[$];
  int            stamp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int msb(input logic [127:0] x);
    int p;
    p = -1;
    for (int i = 0; i < 128; i++) if (x[i]) p = i;
    return p;
  endfunction

  // Reference: exact difference at the small operand's scale, floored back to the large one's.
  function automatic logic [RW-1:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic sub, input logic i2f);
    logic         sa, sb_eff, sign, zsign, sticky;
    logic [62:0]  big, sml;
    logic [127:0] sig_l, sig_s, exact, diff, man;
    int           e_l, eff_l, eff_s, ed, p, lz;
    sa = a[63];
    if (i2f) begin
      diff = 128'(a[51:0]);
      if (diff == 0) return {sa & sub, 11'd0, 55'd0, 1'b0, 1'b1};
      p   = msb(diff);
      man = diff << (54 - p);
      return {sa, 11'(1023 + p), man[54:0], 1'b0, 1'b0};
    end
    sb_eff = b[63] ^ sub;
    zsign  = sa & sb_eff;
    if (a[62:0] >= b[62:0]) begin
      big = a[62:0]; sml = b[62:0]; sign = sa;
    end else begin
      big = b[62:0]; sml = a[62:0]; sign = sb_eff;
    end
    e_l   = int'(big[62:52]);
    eff_l = (e_l == 0) ? 1 : e_l;
    eff_s = (sml[62:52] == 0) ? 1 : int'(sml[62:52]);
    sig_l = 128'({big[62:52] != 0, big[51:0], 2'b00});
    sig_s = 128'({sml[62:52] != 0, sml[51:0], 2'b00});
    ed    = eff_l - eff_s;
    if (ed <= 64) begin
      exact  = (sig_l << ed) - sig_s;
      diff   = exact >> ed;
      sticky = (exact & ((128'd1 << ed) - 128'd1)) != 0;
    end else begin
      sticky = sig_s != 0;
      diff   = sig_l - 128'(sticky);
    end
    if (diff == 0) return {zsign, 11'd0, 55'd0, sticky, 1'b1};
    lz = 54 - msb(diff);
    if (e_l - lz >= 1) begin
      man = diff << lz;
      return {sign, 11'(e_l - lz), man[54:0], sticky, 1'b0};
    end
    man = diff << (eff_l - 1);
    return {sign, 11'd0, man[54:0], sticky, 1'b0};
  endfunction

  task automatic pop_check();
    logic [RW-1:0] got;
    got = {bus.sign_o, bus.exp_o, bus.man_o, bus.sticky_o, bus.zero_o};
    n_pop++;
    if (exp_q.size() == 0) begin
      check("spurious_out", 128'(bus.out_valid), 128'(0));
      return;
    end
    check("result", 128'(got), 128'(exp_q[0]));
    last_res = got;
    last_lat = cyc - stamp_q[0];
    exp_q.delete(0);
    stamp_q.delete(0);
  endtask

  task automatic cycle(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input logic i2f, input logic ordy, input logic fl);
    @(negedge clk);
    bus.in_valid  = v;
    bus.opa       = a;
    bus.opb       = b;
    bus.op_sub    = sub;
    bus.i2f       = i2f;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    cyc++;
    last_acc = v && bus.in_ready;
    if (bus.out_valid && ordy && !fl) pop_check();
    if (fl) begin
      exp_q.delete();
      stamp_q.delete();
    end
    if (last_acc) begin
      exp_q.push_back(model(a, b, sub, i2f));
      stamp_q.push_back(cyc);
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 64'd0, 64'd0, 1'b1, 1'b0, ordy, 1'b0);
  endtask

  task automatic one(input string tag, input logic [63:0] a, input logic [63:0] b, input logic i2f);
    int n;
    cycle(1'b1, a, b, 1'b1, i2f, 1'b1, 1'b0);
    check({tag, "_acc"}, 128'(last_acc), 128'(1));
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      idle(1'b1);
      n++;
    end
    check({tag, "_timeout"}, 128'(exp_q.size()), 128'(0));
    check({tag, "_lat"}, 128'(last_lat), 128'(4));
  endtask

  function automatic logic [63:0] rnd_op(input int e);
    logic [51:0] m;
    m = 52'({$urandom(), $urandom()});
    if ($urandom_range(0, 7) == 0) m = '0;
    return {1'($urandom()), 11'(e), m};
  endfunction

  task automatic rnd_pair(output logic [63:0] a, output logic [63:0] b, output logic i2f);
    int          ea, eb;
    logic [63:0] t;
    ea = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 2046));
    case ($urandom_range(0, 3))
      0:       eb = ea;
      1:       eb = ea - int'($urandom_range(1, 3));
      2:       eb = ea - int'($urandom_range(4, 70));
      default: eb = int'($urandom_range(0, 2046));
    endcase
    if (eb < 0) eb = 0;
    a = rnd_op(ea);
    b = rnd_op(eb);
    if ($urandom_range(0, 7) == 0) b = {1'($urandom()), a[62:0]};
    if ($urandom_range(0, 1) == 1) begin
      t = a; a = b; b = t;
    end
    i2f = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [63:0] a, b;
    logic        f;
    int          k, n, pops0;
    logic [63:0] bp_a[6], bp_b[6];

    bus.in_valid  = 1'b0;
    bus.opa       = '0;
    bus.opb       = '0;
    bus.op_sub    = 1'b1;
    bus.i2f       = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_outs", 128'({bus.out_valid, bus.sign_o, bus.exp_o, bus.man_o, bus.sticky_o, bus.zero_o}), 128'(0));
    rst_n = 1'b1;
    idle(1'b1);

    one("basic", 64'h4008000000000000, 64'h3FF0000000000000, 1'b0);
    check("basic_res", 128'(last_res), 128'({1'b0, 11'h400, 55'h40000000000000, 1'b0, 1'b0}));
    one("cancel", 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0);
    check("cancel_res", 128'(last_res), 128'({1'b0, 11'h000, 55'h0, 1'b0, 1'b1}));
    one("negzero", 64'h8000000000000000, 64'h0000000000000000, 1'b0);
    check("negzero_res", 128'(last_res), 128'({1'b1, 11'h000, 55'h0, 1'b0, 1'b1}));
    one("far", 64'h3FF0000000000000, 64'h3C30000000000000, 1'b0);
    check("far_exp", 128'(last_res[67:57]), 128'(11'h3FE));
    check("far_sticky", 128'(last_res[1]), 128'(1));
    one("denorm", 64'h0010000000000000, 64'h0000000000000001, 1'b0);
    check("denorm_res", 128'(last_res), 128'({1'b0, 11'h000, 1'b0, 52'hFFFFFFFFFFFFF, 2'b00, 1'b0, 1'b0}));
    one("i2f", 64'h0000000000000005, 64'h4008000000000000, 1'b1);
    check("i2f_res", 128'(last_res), 128'({1'b0, 11'h401, 55'h50000000000000, 1'b0, 1'b0}));

    // Backpressure: six ops offered against a stalled sink.
    for (int i = 0; i < 6; i++) rnd_pair(bp_a[i], bp_b[i], f);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(k < 6, bp_a[k % 6], bp_b[k % 6], 1'b1, 1'b0, 1'b0, 1'b0);
      if (last_acc) k++;
    end
    check("bp_accepted", 128'(k), 128'(4));
    check("bp_in_ready", 128'(bus.in_ready), 128'(0));
    pops0 = n_pop;
    n = 0;
    while ((k < 6 || exp_q.size() != 0) && n < 40) begin
      cycle(k < 6, bp_a[k % 6], bp_b[k % 6], 1'b1, 1'b0, 1'b1, 1'b0);
      if (last_acc) k++;
      n++;
    end
    check("bp_results", 128'(n_pop - pops0), 128'(6));

    // Asynchronous reset while a result is being held.
    for (int i = 0; i < 5; i++) begin
      rnd_pair(a, b, f);
      cycle(1'b1, a, b, 1'b1, f, 1'b0, 1'b0);
    end
    check("pre_rst_valid", 128'(bus.out_valid), 128'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async", 128'({bus.out_valid, bus.sign_o, bus.exp_o, bus.man_o, bus.sticky_o, bus.zero_o}), 128'(0));
    exp_q.delete();
    stamp_q.delete();
    idle(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);

    // Flush with three ops in flight, then confirm clean latency afterwards.
    for (int i = 0; i < 3; i++) begin
      rnd_pair(a, b, f);
      cycle(1'b1, a, b, 1'b1, f, 1'b1, 1'b0);
    end
    rnd_pair(a, b, f);
    cycle(1'b1, a, b, 1'b1, f, 1'b0, 1'b1);
    check("flush_in_ready", 128'(bus.in_ready), 128'(0));
    pops0 = n_pop;
    repeat (8) idle(1'b1);
    check("flush_no_out", 128'(n_pop - pops0), 128'(0));
    one("post_flush", 64'h4008000000000000, 64'h3FF0000000000000, 1'b0);

    // Random traffic with random sink stalls.
    for (int c = 0; c < 400; c++) begin
      rnd_pair(a, b, f);
      cycle($urandom_range(0, 3) != 0, a, b, 1'($urandom()), f, $urandom_range(0, 3) != 0, 1'b0);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      idle(1'b1);
      n++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
